// File: rtl/sub_scheduler.sv
// sub_scheduler: round-robin arbiter sharing one Subtractor datapath among N_REQ channels.
// Define SUBSCHED_TIMEOUT_EN to build the WAIT-state timeout abort (res_err); otherwise res_err is 0.
module sub_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                     M100CLK,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_i,
   input  logic [N_REQ*DATA_W-1:0]  req_q,
   output logic [N_REQ-1:0]         req_grant,
   output logic [DATA_W-1:0]        sub_i,
   output logic [DATA_W-1:0]        sub_q,
   output logic                     sub_reset,
   input  logic                     sub_ready,
   input  logic [DATA_W-1:0]        sub_sum,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(N_REQ)-1:0] res_tag,
   output logic [DATA_W-1:0]        res_sum,
   output logic                     res_err,
   output logic                     busy
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   if (N_REQ < 2 || N_REQ > 8 || DATA_W < 1 || TIMEOUT < 1) begin : g_param_check
      $error("sub_scheduler: illegal parameter set");
   end

   logic [1:0]        state_q,     state_d;
   logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
   logic [PTR_W-1:0]  winner_q,    winner_d;
   logic [DATA_W-1:0] sub_i_q,     sub_i_d;
   logic [DATA_W-1:0] sub_q_q,     sub_q_d;
   logic [N_REQ-1:0]  grant_q,     grant_d;
   logic              res_valid_q, res_valid_d;
   logic [PTR_W-1:0]  res_tag_q,   res_tag_d;
   logic [DATA_W-1:0] res_sum_q,   res_sum_d;

`ifdef SUBSCHED_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
   logic              res_err_q,   res_err_d;
`endif

   // First asserted request at or after rr_ptr, searching upward with wrap.
   logic             arb_found;
   logic [PTR_W-1:0] arb_idx;

   always_comb begin
      logic [PTR_W-1:0] cand;
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = rr_ptr_q;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         if (!arb_found && req_valid[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
         cand = (cand == PTR_LAST) ? '0 : cand + PTR_ONE;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      winner_d    = winner_q;
      sub_i_d     = sub_i_q;
      sub_q_d     = sub_q_q;
      grant_d     = '0;
      res_valid_d = res_valid_q;
      res_tag_d   = res_tag_q;
      res_sum_d   = res_sum_q;
`ifdef SUBSCHED_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      res_err_d   = res_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               winner_d          = arb_idx;
               sub_i_d           = req_i[arb_idx*DATA_W +: DATA_W];
               sub_q_d           = req_q[arb_idx*DATA_W +: DATA_W];
               grant_d[arb_idx]  = 1'b1;
               state_d           = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef SUBSCHED_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (sub_ready) begin
               res_sum_d   = sub_sum;
               res_valid_d = 1'b1;
               res_tag_d   = winner_q;
               state_d     = S_HOLD;
            end
`ifdef SUBSCHED_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               res_sum_d   = '0;
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_tag_d   = winner_q;
               state_d     = S_HOLD;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_ONE;
            end
`endif
         end
         S_HOLD: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               rr_ptr_d    = (winner_q == PTR_LAST) ? '0 : winner_q + PTR_ONE;
               state_d     = S_IDLE;
`ifdef SUBSCHED_TIMEOUT_EN
               res_err_d   = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge M100CLK) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         winner_q    <= '0;
         sub_i_q     <= '0;
         sub_q_q     <= '0;
         grant_q     <= '0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
         res_sum_q   <= '0;
`ifdef SUBSCHED_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         res_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         winner_q    <= winner_d;
         sub_i_q     <= sub_i_d;
         sub_q_q     <= sub_q_d;
         grant_q     <= grant_d;
         res_valid_q <= res_valid_d;
         res_tag_q   <= res_tag_d;
         res_sum_q   <= res_sum_d;
`ifdef SUBSCHED_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         res_err_q   <= res_err_d;
`endif
      end
   end

   assign req_grant = grant_q;
   assign sub_i     = sub_i_q;
   assign sub_q     = sub_q_q;
   assign sub_reset = (state_q == S_IDLE) || (state_q == S_HOLD);
   assign busy      = (state_q != S_IDLE);
   assign res_valid = res_valid_q;
   assign res_tag   = res_tag_q;
   assign res_sum   = res_sum_q;
`ifdef SUBSCHED_TIMEOUT_EN
   assign res_err   = res_err_q;
`else
   assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sub_scheduler.sv
// Bench for sub_scheduler: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the scheduler.
`timescale 1ns/1ps
module tb_sub_scheduler;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int TMO = 16;
`ifdef SUBSCHED_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_i = '0;
   logic [N*DW-1:0] req_q = '0;
   logic [N-1:0]    req_grant;
   logic [DW-1:0]   sub_i, sub_q;
   logic            sub_reset;
   logic            sub_ready = 1'b0;
   logic [DW-1:0]   sub_sum = '0;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [1:0]      res_tag;
   logic [DW-1:0]   res_sum;
   logic            res_err;
   logic            busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sub_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .M100CLK(clk), .reset(reset), .req_valid(req_valid), .req_i(req_i), .req_q(req_q),
      .req_grant(req_grant), .sub_i(sub_i), .sub_q(sub_q), .sub_reset(sub_reset),
      .sub_ready(sub_ready), .sub_sum(sub_sum), .res_valid(res_valid), .res_ready(res_ready),
      .res_tag(res_tag), .res_sum(res_sum), .res_err(res_err), .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: one owner at a time, age counts cycles since the grant.
   bit            m_init = 1'b0;
   bit            m_active = 1'b0;
   bit            m_res_valid = 1'b0;
   bit            m_res_err = 1'b0;
   int            m_ptr = 0, m_owner = 0, m_age = 0, m_grant = -1, m_res_tag = 0, m_c;
   logic [DW-1:0] m_sub_i = '0, m_sub_q = '0, m_res_sum = '0;

   always @(posedge clk) begin
      m_grant = -1;
      if (!reset) begin
         m_init = 1'b1; m_active = 1'b0; m_ptr = 0;
         m_sub_i = '0; m_sub_q = '0;
         m_res_valid = 1'b0; m_res_err = 1'b0; m_res_tag = 0; m_res_sum = '0;
      end else if (!m_active) begin
         for (int k = 0; k < N; k++) begin
            m_c = (m_ptr + k) % N;
            if (m_grant < 0 && req_valid[m_c]) m_grant = m_c;
         end
         if (m_grant >= 0) begin
            m_active = 1'b1; m_owner = m_grant; m_age = 0;
            m_sub_i = req_i[m_grant*DW +: DW];
            m_sub_q = req_q[m_grant*DW +: DW];
         end
      end else if (!m_res_valid) begin
         if (m_age >= 1 && sub_ready) begin
            m_res_valid = 1'b1; m_res_sum = sub_sum; m_res_tag = m_owner;
         end else if (TMO_EN && m_age >= TMO) begin
            m_res_valid = 1'b1; m_res_err = 1'b1; m_res_sum = '0; m_res_tag = m_owner;
         end
         m_age++;
      end else if (res_ready) begin
         m_res_valid = 1'b0; m_res_err = 1'b0;
         m_ptr = (m_owner + 1) % N;
         m_active = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("req_grant", req_grant, (m_grant < 0) ? 64'd0 : (64'd1 << m_grant));
         check("sub_i", sub_i, m_sub_i);
         check("sub_q", sub_q, m_sub_q);
         check("sub_reset", sub_reset, !m_active || m_res_valid);
         check("busy", busy, m_active);
         check("res_valid", res_valid, m_res_valid);
         check("res_tag", res_tag, m_res_tag);
         check("res_sum", res_sum, m_res_sum);
         check("res_err", res_err, m_res_err);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_grant(output int idx, output int cyc);
      idx = -1;
      cyc = 0;
      while (idx < 0 && cyc < 40) begin
         step();
         cyc++;
         for (int k = 0; k < N; k++) if (req_grant[k]) idx = k;
      end
      if (idx < 0) begin
         checks++;
         failures++;
         $display("FAIL wait_grant: no grant within 40 cycles at %0t", $time);
      end
   endtask

   initial begin
      int g, cyc, n;
      logic [DW-1:0] held_sum;
      logic [1:0]    held_tag;
      bit stable;

      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_sub_reset", sub_reset, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_sub_i", sub_i, 0);
      check("rst_grant", req_grant, 0);
      reset = 1'b1;

      // Single request, sub_ready in the first WAIT cycle.
      req_valid = 4'b0001; req_i[31:0] = 32'h8000000A; req_q[31:0] = 32'h80000003; res_ready = 1'b0;
      step();
      check("single_grant", req_grant, 4'b0001);
      check("single_sub_i", sub_i, 32'h8000000A);
      check("single_sub_q", sub_q, 32'h80000003);
      req_valid = '0;
      step();
      check("single_grant_gone", req_grant, 0);
      check("single_no_res", res_valid, 0);
      sub_ready = 1'b1; sub_sum = 32'h80000007;
      step();
      check("single_res_valid", res_valid, 1);
      check("single_res_sum", res_sum, 32'h80000007);
      check("single_res_tag", res_tag, 0);
      sub_ready = 1'b0; res_ready = 1'b1;
      step();
      check("single_done", res_valid, 0);
      check("single_idle", busy, 0);

      // Round-robin with all channels requesting.
      reset = 1'b0; step(); reset = 1'b1;
      req_valid = '1; res_ready = 1'b1; sub_ready = 1'b1; sub_sum = 32'h0000_1234;
      for (int i = 0; i < 5; i++) begin
         wait_grant(g, cyc);
         check("rr_order", g, i % N);
         if (i > 0) check("rr_period", cyc, 4);
      end
      wait_grant(g, cyc);
      check("rr_sixth", g, 1);
      req_valid = 4'b0011;
      wait_grant(g, cyc);
      check("rr_wrap_ch0", g, 0);

      // Backpressure while channel 1 waits.
      req_valid = 4'b0010; res_ready = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin step(); n++; end
      check("bp_res_valid", res_valid, 1);
      held_sum = res_sum; held_tag = res_tag;
      check("bp_tag", held_tag, 0);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sub_ready = $urandom_range(0, 1); sub_sum = $urandom;
         step();
         if (res_sum !== held_sum || res_tag !== held_tag || busy !== 1'b1 ||
             req_grant !== 4'b0000 || res_valid !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", stable, 1);
      res_ready = 1'b1; sub_ready = 1'b0;
      step();
      check("bp_released", res_valid, 0);
      step();
      check("bp_next_grant", req_grant, 4'b0010);

      // Reset during WAIT.
      req_valid = '0;
      step();
      check("rw_in_wait", busy, 1);
      reset = 1'b0;
      step();
      check("rw_busy", busy, 0);
      check("rw_sub_reset", sub_reset, 1);
      check("rw_res_valid", res_valid, 0);
      check("rw_res_sum", res_sum, 0);
      check("rw_sub_i", sub_i, 0);
      reset = 1'b1; req_valid = '1;
      wait_grant(g, cyc);
      check("rw_first_ch0", g, 0);
      req_valid = '0; sub_ready = 1'b1;
      repeat (4) step();

`ifdef SUBSCHED_TIMEOUT_EN
      // Subtractor never answers.
      reset = 1'b0; step(); reset = 1'b1;
      req_valid = 4'b0001; sub_ready = 1'b0; res_ready = 1'b0;
      wait_grant(g, cyc);
      req_valid = '0;
      n = 0;
      while (!res_valid && n < 40) begin step(); n++; end
      check("tmo_latency", n, 17);
      check("tmo_err", res_err, 1);
      check("tmo_sum", res_sum, 0);
      res_ready = 1'b1;
      step();
      check("tmo_err_clear", res_err, 0);
      check("tmo_valid_clear", res_valid, 0);
`endif

      // Random traffic; requesters hold operands until granted.
      for (int t = 0; t < 3000; t++) begin
         step();
         for (int k = 0; k < N; k++) begin
            if (req_valid[k] && req_grant[k]) begin
               if ($urandom_range(0, 1) == 0) req_valid[k] = 1'b0;
               else begin
                  req_i[k*DW +: DW] = $urandom;
                  req_q[k*DW +: DW] = $urandom;
               end
            end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
               req_valid[k] = 1'b1;
               req_i[k*DW +: DW] = $urandom;
               req_q[k*DW +: DW] = $urandom;
            end
         end
         sub_ready = ($urandom_range(0, 3) == 0);
         sub_sum   = $urandom;
         res_ready = $urandom_range(0, 1);
         reset     = ($urandom_range(0, 399) != 0);
      end
      reset = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sub_scheduler.md
# sub_scheduler

Round-robin scheduler that shares the single Subtractor datapath in the DRFM sample path between `N_REQ` requesting channels. It accepts one I/Q operand pair at a time and drives the Subtractor's operands and active-high reset. It captures the first `output_ready` pulse of the transaction and returns the offset-binary result, tagged with the requester index, through a valid/ready handshake. It sits between the per-channel sample formatters and the Subtractor instance.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand and result width.
- `TIMEOUT`, 16: maximum WAIT cycles before abort. Used only with `SUBSCHED_TIMEOUT_EN`.

Ports:
- `M100CLK`  in  1  100 MHz system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  per-channel request.
- `req_i`  in  N_REQ*DATA_W  packed I operands; channel k at `[k*DATA_W +: DATA_W]`, offset binary.
- `req_q`  in  N_REQ*DATA_W  packed Q operands, same packing.
- `req_grant`  out  N_REQ  one-hot, one-cycle pulse: operands of channel k latched.
- `sub_i`, `sub_q`  out  DATA_W  operands to the Subtractor.
- `sub_reset`  out  1  active-high reset to the Subtractor.
- `sub_ready`  in  1  Subtractor `output_ready`.
- `sub_sum`  in  DATA_W  Subtractor `sum`, offset binary.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_tag`  out  $clog2(N_REQ)  index of the channel that owns the result.
- `res_sum`  out  DATA_W  captured `sub_sum`.
- `res_err`  out  1  result aborted by timeout. Tied 0 without the macro.
- `busy`  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, HOLD. Encoding is free.
- **IDLE**
  - `sub_reset`=1.
  - Arbiter selects the first asserted `req_valid` at or after pointer `rr_ptr`, searching upward with wrap-around.
  - If any request is valid: latch the winner's `req_i` and `req_q` into `sub_i` and `sub_q`, store the winner index, pulse `req_grant[winner]`, and go to ISSUE.
- **ISSUE**
  - `sub_reset`=0, operands held.
  - Always go to WAIT after one cycle. This absorbs the Subtractor's internal reset register stage.
- **WAIT**
  - `sub_reset`=0.
  - On the first cycle with `sub_ready`=1: capture `sub_sum` into `res_sum`, set `res_valid`=1, set `res_tag`=winner, set `sub_reset`=1, and go to HOLD.
  - Later `sub_ready` pulses are ignored.
- **HOLD**
  - `sub_reset`=1. `res_*` are held stable until accepted.
  - On `res_valid && res_ready`: clear `res_valid`, set `rr_ptr` = winner+1 mod `N_REQ`, and go to IDLE.
- Requests are never accepted outside IDLE. Requesters hold `req_valid` and operands until they see `req_grant`.
- The result is passed through unmodified; no width growth or sign conversion.
- `sub_i` and `sub_q` change only on a grant.

## Timing

- Reset (`reset`=0 at an edge):
  - State IDLE, `rr_ptr`=0.
  - `req_grant`=0, `sub_i`=0, `sub_q`=0, `sub_reset`=1.
  - `res_valid`=0, `res_tag`=0, `res_sum`=0, `res_err`=0, `busy`=0.
- Reset in any state aborts the transaction. The result is discarded with no `res_valid` pulse.
- Latency:
  - Edge E0 (IDLE, request valid) grants.
  - E1 enters WAIT.
  - The earliest `res_valid`=1 is after E2, if `sub_ready` is high in the first WAIT cycle.
- Minimum request-to-request period is 4 cycles with `res_ready` tied high.
- `req_grant` is registered and is high only in the cycle after the latching edge.
- `res_ready` asserted in the same cycle `res_valid` first rises completes the handshake at that edge.
- `sub_ready` while in IDLE, ISSUE or HOLD is ignored.

## Configuration

- `SUBSCHED_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT.
  - If `sub_ready` is not seen within `TIMEOUT` WAIT cycles, go to HOLD with `res_valid`=1, `res_err`=1 and `res_sum`=0.
  - `res_err` clears on handshake.
- `SUBSCHED_TIMEOUT_EN` not defined:
  - WAIT lasts until `sub_ready`.
  - No counter is built; `res_err` is constant 0.

## Test plan

- **Single request:** `req_valid`=0001, `req_i`=0x8000000A, `req_q`=0x80000003; model `sub_ready` in the first WAIT cycle with `sub_sum`=0x80000007 → `req_grant`=0001 one cycle, `res_valid` after 3 edges, `res_tag`=0, `res_sum`=0x80000007.
- **Round-robin fairness:** `req_valid`=1111 held, `res_ready`=1 → grants in order channel 0,1,2,3,0, each 4 cycles apart. Then with `rr_ptr`=2 and `req_valid`=0011 → channel 0 granted.
- **Backpressure:** `res_ready`=0 for 10 cycles after `res_valid` → `res_sum` and `res_tag` stable, `busy`=1, no new grant despite `req_valid`=0010. Grant follows the cycle after `res_ready`=1.
- **Stray ready:** `sub_ready` pulsed in IDLE, ISSUE and HOLD, and twice in WAIT → exactly one result, carrying the `sub_sum` of the first WAIT pulse.
- **Reset mid-WAIT:** `reset`=0 for one edge in WAIT → all outputs at reset values, `sub_reset`=1, no `res_valid`. Next request goes to channel 0 first.
- **Timeout (macro defined, `TIMEOUT`=16):** `sub_ready` never asserted → `res_valid`=1, `res_err`=1, `res_sum`=0 after 16 WAIT cycles; both clear on handshake.
